ux607_reset_seq_sync: RTL and testbench

UX607_RESET_SEQ_SYNC -- requirements
Module: ux607_reset_seq_sync

---
 rtl/ux607_reset_seq_sync.sv | 110 +++++++++++
 tb/tb_ux607_reset_seq_sync.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/ux607_reset_seq_sync.sv
// rtl/ux607_reset_seq_sync.sv - reset release synchroniser with stretched, staggered per-channel release
module ux607_reset_seq_sync #(
  parameter int SYNC_DEPTH     = 3,
  parameter int NUM_CH         = 4,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              test_mode,
  input  logic              sw_reset_req,
  input  logic [NUM_CH-1:0] ch_hold,
  output logic [NUM_CH-1:0] sync_reset_n,
  output logic              seq_done
);

  localparam int MAX_CYC = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = $clog2(NUM_CH + 1);

  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] STAGGER_LAST = CW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_END      = IW'(NUM_CH);

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [SYNC_DEPTH-1:0] sync_q;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [NUM_CH-1:0] rst_q;
  logic              done_q;
  logic [NUM_CH-1:0] ch_sel;
  logic              sync_rel;

  assign sync_rel = sync_q[SYNC_DEPTH-1];
  // One-hot select of the channel currently due, avoids indexing with the wider idx.
  assign ch_sel   = NUM_CH'(1) << idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ASSERT;
      cnt    <= '0;
      idx    <= '0;
      rst_q  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ASSERT: begin
          if (sync_rel) begin
            state <= STRETCH;
            cnt   <= '0;
          end
        end
        STRETCH: begin
          if (cnt == STRETCH_LAST) begin
            state    <= RELEASE;
            rst_q[0] <= 1'b1;
            idx      <= IW'(1);
            cnt      <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (idx == IDX_END) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else if (cnt == STAGGER_LAST) begin
            // Held channel waits here with the counter parked at its last value.
            if (!(|(ch_hold & ch_sel))) begin
              rst_q <= rst_q | ch_sel;
              idx   <= idx + IW'(1);
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (sw_reset_req) begin
            state  <= STRETCH;
            cnt    <= '0;
            idx    <= '0;
            rst_q  <= '0;
            done_q <= 1'b0;
          end
        end
        default: state <= ASSERT;
      endcase
    end
  end

  assign sync_reset_n = test_mode ? {NUM_CH{reset_n}} : rst_q;
  assign seq_done     = test_mode ? reset_n : done_q;

endmodule

// File: tb/tb_ux607_reset_seq_sync.sv
// tb/tb_ux607_reset_seq_sync.sv - directed bench for ux607_reset_seq_sync (default and minimal parameter sets)
module tb_ux607_reset_seq_sync;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       test_mode = 1'b0;
  logic       sw_reset_req = 1'b0;
  logic [3:0] ch_hold = 4'b0000;
  logic [3:0] sync_reset_n;
  logic       seq_done;

  logic       sw_req_s = 1'b0;
  logic [0:0] ch_hold_s = 1'b0;
  logic [0:0] sync_reset_n_s;
  logic       seq_done_s;

  int n_cmp = 0;
  int n_fail = 0;
  int edge_n = 0;
  int t_ch[4];
  int t_done;
  int s_ch0;
  int s_done;

  always #5 clock = ~clock;

  ux607_reset_seq_sync dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .test_mode    (test_mode),
    .sw_reset_req (sw_reset_req),
    .ch_hold      (ch_hold),
    .sync_reset_n (sync_reset_n),
    .seq_done     (seq_done)
  );

  ux607_reset_seq_sync #(
    .SYNC_DEPTH     (2),
    .NUM_CH         (1),
    .STRETCH_CYCLES (1),
    .STAGGER_CYCLES (1)
  ) dut_min (
    .clock        (clock),
    .reset_n      (reset_n),
    .test_mode    (test_mode),
    .sw_reset_req (sw_req_s),
    .ch_hold      (ch_hold_s),
    .sync_reset_n (sync_reset_n_s),
    .seq_done     (seq_done_s)
  );

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] exp_main();
    logic [4:0] e;
    for (int k = 0; k < 4; k++) e[k] = (edge_n >= t_ch[k]);
    e[4] = (edge_n >= t_done);
    return e;
  endfunction

  function automatic logic [4:0] exp_min();
    return {3'b000, (edge_n >= s_done), (edge_n >= s_ch0)};
  endfunction

  task automatic run_to(input int last);
    while (edge_n < last) begin
      @(posedge clock);
      #1;
      edge_n++;
      check($sformatf("main@%0d", edge_n), {seq_done, sync_reset_n}, exp_main());
      check($sformatf("min@%0d", edge_n), {3'b000, seq_done_s, sync_reset_n_s}, exp_min());
    end
  endtask

  task automatic set_default_times();
    t_ch[0] = 20; t_ch[1] = 24; t_ch[2] = 28; t_ch[3] = 32; t_done = 33;
    s_ch0 = 4; s_done = 5;
  endtask

  task automatic do_reset(input logic [3:0] hold);
    reset_n = 1'b0;
    ch_hold = hold;
    repeat (3) @(posedge clock);
    #1;
    check("reset_main", {seq_done, sync_reset_n}, 5'b00000);
    check("reset_min", {3'b000, seq_done_s, sync_reset_n_s}, 5'b00000);
    reset_n = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    // Plain power-on sequence
    set_default_times();
    do_reset(4'b0000);
    run_to(36);

    // ch2 held past its due edge; released channels and DONE ignore hold
    do_reset(4'b0100);
    t_ch[2] = 40; t_ch[3] = 44; t_done = 45;
    run_to(39);
    ch_hold = 4'b0011;
    run_to(46);
    ch_hold = 4'b1111;
    run_to(50);
    ch_hold = 4'b0000;

    // Sub-cycle reset pulse mid-RELEASE restarts everything
    set_default_times();
    do_reset(4'b0000);
    run_to(24);
    #2;
    reset_n = 1'b0;
    #1;
    check("pulse_main", {seq_done, sync_reset_n}, 5'b00000);
    check("pulse_min", {3'b000, seq_done_s, sync_reset_n_s}, 5'b00000);
    reset_n = 1'b1;
    edge_n = 0;
    run_to(50);

    // Software replay from DONE; a second request during STRETCH is ignored
    t_ch[0] = 67; t_ch[1] = 71; t_ch[2] = 75; t_ch[3] = 79; t_done = 80;
    sw_reset_req = 1'b1;
    run_to(51);
    sw_reset_req = 1'b0;
    run_to(59);
    sw_reset_req = 1'b1;
    run_to(60);
    sw_reset_req = 1'b0;
    run_to(82);

    // Test-mode bypass follows reset_n with no clock involvement
    test_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      reset_n = 1'b0;
      #1;
      check("tm_low_main", {seq_done, sync_reset_n}, 5'b00000);
      check("tm_low_min", {3'b000, seq_done_s, sync_reset_n_s}, 5'b00000);
      reset_n = 1'b1;
      #1;
      check("tm_high_main", {seq_done, sync_reset_n}, 5'b11111);
      check("tm_high_min", {3'b000, seq_done_s, sync_reset_n_s}, 5'b00011);
      #3;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
